// File: rtl/hash_stream_frontend.sv
// Stream command front end for the hash-table core: accepts packed commands,
// issues one core request at a time and queues status-tagged responses.
module hash_stream_frontend #(
  parameter int unsigned KEY_WIDTH       = 2,
  parameter int unsigned DATA_WIDTH      = 28,
  parameter int unsigned RESP_FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  localparam int unsigned W              = 2 + KEY_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [W-1:0]          data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  core_req_o,
  output logic [1:0]            core_op_o,
  output logic [KEY_WIDTH-1:0]  core_key_o,
  output logic [DATA_WIDTH-1:0] core_data_o,
  input  logic                  core_ack_i,
  input  logic                  core_hit_i,
  input  logic                  core_full_i,
  input  logic [DATA_WIDTH-1:0] core_data_i,
  output logic                  err_timeout_o,
  output logic [15:0]           cmd_count_o
);

  localparam int unsigned PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOOKUP = 2'b01;
  localparam logic [1:0] OP_INSERT = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISS    = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_q, req_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [15:0]           cmd_cnt_q, cmd_cnt_d;
  logic [W-1:0]          mem_q [RESP_FIFO_DEPTH];
  logic [W-1:0]          mem_d [RESP_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [W-1:0]          resp;
  logic [1:0]            in_op;

  assign in_op   = data_i[W-1:W-2];
  assign ready_o = !reset && (state_q == S_IDLE) && (cnt_q < CNT_W'(RESP_FIFO_DEPTH));
  assign accept  = ready_o && valid_i;
  assign pop     = valid_q && ready_i;

  // Next-state, response formation and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    rdata_d   = rdata_q;
    req_d     = req_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    cmd_cnt_d = cmd_cnt_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    resp      = '0;

    case (state_q)
      S_IDLE: begin
        if (accept && (in_op != OP_NOP)) begin
          op_d      = in_op;
          key_d     = data_i[W-3:DATA_WIDTH];
          rdata_d   = data_i[DATA_WIDTH-1:0];
          cmd_cnt_d = cmd_cnt_q + 16'd1;
          req_d     = 1'b1;
          tmo_d     = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (core_ack_i) begin
          push    = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
          case (op_q)
            OP_LOOKUP: resp = core_hit_i ? {ST_OK, key_q, core_data_i}
                                         : {ST_MISS, key_q, {DATA_WIDTH{1'b0}}};
            OP_INSERT: resp = {core_full_i ? ST_FULL : ST_OK, key_q, rdata_q};
            default:   resp = {core_hit_i ? ST_OK : ST_MISS, key_q, {DATA_WIDTH{1'b0}}};
          endcase
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Ack on this final cycle would have taken the branch above.
          push    = 1'b1;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
          resp    = {ST_TIMEOUT, key_q, {DATA_WIDTH{1'b0}}};
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = resp;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      key_q     <= '0;
      rdata_q   <= '0;
      req_q     <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      cmd_cnt_q <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      rdata_q   <= rdata_d;
      req_q     <= req_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      cmd_cnt_q <= cmd_cnt_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
    end
  end

  assign data_o        = mem_q[rd_ptr_q];
  assign valid_o       = valid_q;
  assign core_req_o    = req_q;
  assign core_op_o     = op_q;
  assign core_key_o    = key_q;
  assign core_data_o   = rdata_q;
  assign err_timeout_o = err_q;
  assign cmd_count_o   = cmd_cnt_q;

endmodule

// File: doc/hash_stream_frontend.md
# hash_stream_frontend

Stream-side command front end for the hash-table core; successor to the fixed-format AXI wrapper. Accepts packed command words (opcode, key, data) over a valid/ready input, issues one request at a time to the hash-table core over a req/ack interface, and returns status-tagged response words through a parametrised response FIFO. Adds DELETE and NOP opcodes, miss/full/timeout status reporting, output backpressure buffering and a command counter.

## Interface
- KEY_WIDTH, 2, key bits per command
- DATA_WIDTH, 28, payload bits per command
- RESP_FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2
- TIMEOUT_CYCLES, 64, maximum cycles core_req_o may stay high without core_ack_i; >= 1
- Derived: W = 2 + KEY_WIDTH + DATA_WIDTH

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_i  in  W  command: [W-1:W-2] opcode, [W-3:DATA_WIDTH] key, [DATA_WIDTH-1:0] data
- valid_i  in  1  command valid
- ready_o  out  1  command accepted when valid_i && ready_o at a rising edge
- data_o  out  W  response: [W-1:W-2] status, [W-3:DATA_WIDTH] key echo, [DATA_WIDTH-1:0] data
- valid_o  out  1  response FIFO not empty
- ready_i  in  1  response popped when valid_o && ready_i
- core_req_o  out  1  request to core
- core_op_o  out  2  opcode (01 lookup, 10 insert, 11 delete)
- core_key_o  out  KEY_WIDTH  request key
- core_data_o  out  DATA_WIDTH  request data
- core_ack_i  in  1  core completed request this cycle
- core_hit_i  in  1  key found (lookup/delete), sampled with ack
- core_full_i  in  1  insert failed, no free slot, sampled with ack
- core_data_i  in  DATA_WIDTH  lookup result, sampled with ack
- err_timeout_o  out  1  one-cycle pulse per timed-out request
- cmd_count_o  out  16  accepted non-NOP commands, wraps 0xFFFF -> 0

## Operation
- Opcodes: 00 NOP (consumed, no core request, no response), 01 LOOKUP, 10 INSERT, 11 DELETE.
- FSM: IDLE, REQ. IDLE: ready_o = (count < RESP_FIFO_DEPTH). Accept of non-NOP latches opcode/key/data, increments cmd_count_o, -> REQ. REQ: ready_o = 0, core_req_o = 1, core_op/key/data stable; timeout counter increments each cycle.
- REQ exit on core_ack_i: push response, -> IDLE. Status/data: LOOKUP hit -> 00, core_data_i; LOOKUP miss -> 01, 0; INSERT !full -> 00, request data; INSERT full -> 10, request data; DELETE hit -> 00, 0; DELETE miss -> 01, 0. Key field always echoes request key.
- REQ exit on timeout: no ack in TIMEOUT_CYCLES cycles -> push status 11, data 0, -> IDLE, err_timeout_o pulses next cycle. Ack on the final cycle wins (no timeout).
- core_ack_i/hit/full/data ignored outside REQ.
- FIFO room guaranteed: acceptance requires count < depth, count only falls while in REQ. Push and pop in same cycle allowed at any occupancy; count unchanged.
- Pointers wrap modulo RESP_FIFO_DEPTH; count width clog2(depth)+1.

## Timing
- Reset (edge with reset high): state IDLE, FIFO empty, valid_o 0, core_req_o 0, err_timeout_o 0, cmd_count_o 0, timeout counter 0; ready_o 0 while reset high. Reset in REQ abandons request; core_req_o low from next cycle, no response.
- Accept at edge T: core_req_o high cycle T..T+1 boundary onward (first REQ cycle T+1). Ack in cycle T+1 -> valid_o high in T+2, ready_o high in T+2 (room permitting). Minimum latency 2 cycles, peak throughput one command per 2 cycles.
- NOP: accepted in IDLE, stays IDLE, accepts back-to-back every cycle.
- data_o is FIFO head, stable while valid_o && !ready_i.
- Timeout: core_req_o high exactly TIMEOUT_CYCLES cycles, then low; response visible the cycle after the last REQ cycle.

## Test plan
- Defaults; data_i = 0x80000001, core acks first REQ cycle, full=0 -> data_o = 0x00000001, valid_o 2 cycles after accept, cmd_count_o = 1.
- LOOKUP 0x50000000, ack hit=1 core_data_i = 0x0ABCDEF -> 0x10ABCDEF; repeat with hit=0 -> 0x50000000.
- INSERT 0xB0000005 with core_full_i=1 -> 0xB0000005 (status 10); DELETE 0xE0000000 hit=1 -> 0x20000000.
- TIMEOUT_CYCLES=8, DELETE 0xE0000000, no ack -> core_req_o high 8 cycles, response 0xE0000000, err_timeout_o one pulse; variant with ack on cycle 8 -> status 00, no pulse.
- ready_i=0, 5 LOOKUPs each acked -> 4 responses queued, ready_o held 0; single pop -> fifth accepted; drain yields all 5 in order; NOPs interleaved produce no responses and don't count.
- Reset asserted mid-REQ and with FIFO non-empty -> next cycle valid_o=0, core_req_o=0, cmd_count_o=0; late ack ignored, no response.
